wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of cmd_adr and the Wishbone address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the data paths; SEL width = DATA_WIDTH/8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries; power of two, >=2.
REQ-004 SHALL have parameter TIMEOUT, default 16: bus cycles allowed before a cycle is abandoned; >=2.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid  input  1  command present.
REQ-008 SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-009 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cmd_adr  input  ADDR_WIDTH  address.
REQ-011 SHALL have port cmd_dat  input  DATA_WIDTH  write data.
REQ-012 SHALL have port cmd_sel  input  DATA_WIDTH/8  byte selects.
REQ-013 SHALL have port rsp_valid  output  1  response held.
REQ-014 SHALL have port rsp_ready  input  1  response consumed.
REQ-015 SHALL have port rsp_dat  output  DATA_WIDTH  read data (0 for writes, ERR and timeout).
REQ-016 SHALL have port rsp_err  output  1  cycle terminated by ERR.
REQ-017 SHALL have port rsp_tmo  output  1  cycle terminated by timeout.
REQ-018 SHALL have port busy  output  1  FIFO non-empty, or FSM not IDLE, or rsp_valid high.
REQ-019 SHALL have port m  wb_if.master  -  Wishbone master: ADR, DAT_W, DAT_R, CYC, STB, WE, SEL, ACK, ERR.

Function
REQ-020 SHALL write a command into the FIFO on each edge with cmd_valid && cmd_ready; cmd_ready = !full, with no combinational path from the pop.
REQ-021 SHALL use a two-state FSM: IDLE and BUS.
REQ-022 SHALL go from IDLE to BUS on the edge where the FIFO is non-empty and (rsp_valid==0 or rsp_ready==1).
- On that edge: pop the head entry and register it into ADR/DAT_W/WE/SEL.
- CYC and STB go high and the timeout counter is cleared.
REQ-023 SHALL hold CYC, STB, ADR, DAT_W, WE and SEL stable throughout BUS.
REQ-024 SHALL terminate a cycle on the first edge in BUS where ACK or ERR is sampled high, or where the counter reaches TIMEOUT-1 with neither high.
- Same edge: CYC/STB go low, FSM returns to IDLE, rsp_valid goes high.
REQ-025 SHALL capture the response on termination as follows:
- ACK, read: rsp_dat = DAT_R.
- ACK, write: rsp_dat = 0.
- ERR: rsp_err = 1, rsp_dat = 0.
- Timeout: rsp_tmo = 1, rsp_dat = 0.
REQ-026 SHALL give ERR priority when ACK and ERR are high together, and give ACK/ERR priority over a timeout expiring on the same edge.
REQ-027 SHALL keep CYC low for at least one cycle between consecutive bus cycles, so a slave that acks one cycle after seeing STB never acks twice.
REQ-028 SHALL clear rsp_valid on an edge with rsp_ready high unless a new response loads on the same edge.
- rsp_dat/rsp_err/rsp_tmo hold while rsp_valid is high and unconsumed.
REQ-029 SHALL NOT start a bus cycle while an unconsumed response is held (single response slot).
REQ-030 SHALL present CYC high after edge E+1 and rsp_valid high after edge E+3 for a command accepted at edge E, into an empty FIFO, against a slave that acks one cycle after STB.
REQ-031 SHALL accept a push while popping; a push when full is impossible because cmd_ready is low.
REQ-032 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and keep an extra wrap bit to distinguish full from empty.

Reset
REQ-033 SHALL, while rstn is low and independently of clk, force:
- FSM = IDLE; FIFO empty; cmd_ready = 1.
- CYC = STB = WE = 0; ADR = DAT_W = SEL = 0.
- rsp_valid = rsp_err = rsp_tmo = 0; rsp_dat = 0; busy = 0; counter = 0.
REQ-034 SHALL, on reset asserted mid-cycle, drop CYC/STB immediately, discard the in-flight and queued commands, and produce no response for them.

Verification
REQ-035 SHALL cover: read of 0x10 to a slave returning ACK one cycle after STB and DAT_R=0xDEADBEEF -> rsp_valid 3 cycles after acceptance, rsp_dat=0xDEADBEEF, rsp_err=rsp_tmo=0, one ACK.
REQ-036 SHALL cover: 5 commands offered back-to-back with rsp_ready=0, FIFO_DEPTH=4 -> one bus cycle runs and 4 are queued; cmd_ready low until rsp_ready=1; all 5 complete in order, CYC low >=1 cycle between them.
REQ-037 SHALL cover: slave never asserts ACK/ERR, TIMEOUT=16 -> CYC high exactly 16 cycles, then rsp_tmo=1, rsp_dat=0.
REQ-038 SHALL cover: slave asserts ACK and ERR together on a write -> rsp_err=1, rsp_tmo=0, rsp_dat=0.
REQ-039 SHALL cover: rstn pulled low mid-BUS with 2 commands queued -> CYC/STB low before the next edge, rsp_valid=0, cmd_ready=1, busy=0; no response after reset release.
REQ-040 SHALL cover: random commands with random rsp_ready against the always-acking slave -> response count equals command count, in order, no STB change while CYC is high.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus bundle shared by the command master and its slave.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, cyc, stb, we, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, cyc, stb, we, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Command-queue Wishbone master: buffers commands in a small FIFO and runs
// them one at a time as single Wishbone cycles, returning one response each.
//
// state | meaning
// IDLE  | no cycle in flight; launches the FIFO head once the response slot is free
// BUS   | CYC/STB asserted, waiting for ACK, ERR or the cycle timeout
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [DATA_WIDTH-1:0]   cmd_dat,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic                    rsp_err,
  output logic                    rsp_tmo,
  output logic                    busy,
  wb_if.master                    m
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = $clog2(TIMEOUT);
  localparam int ENT_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH + SEL_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t                 r_state;
  logic [ENT_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH:0]     r_wr_ptr;
  logic [PTR_WIDTH:0]     r_rd_ptr;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]  r_adr;
  logic [DATA_WIDTH-1:0]  r_dat_w;
  logic                   r_we;
  logic [SEL_WIDTH-1:0]   r_sel;
  logic                   r_cyc;
  logic                   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_dat;
  logic                   r_rsp_err;
  logic                   r_rsp_tmo;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [ENT_WIDTH-1:0]   w_head;
  logic                   w_head_we;
  logic [ADDR_WIDTH-1:0]  w_head_adr;
  logic [DATA_WIDTH-1:0]  w_head_dat;
  logic [SEL_WIDTH-1:0]   w_head_sel;

  // Full/empty come only from registered pointers, so cmd_ready never
  // depends combinationally on the pop.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {PTR_WIDTH{1'b0}}});
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty && (!r_rsp_valid || rsp_ready);

  assign w_head = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
  assign {w_head_we, w_head_adr, w_head_dat, w_head_sel} = w_head;

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Bus-cycle FSM with registered Wishbone outputs and response slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_adr       <= '0;
      r_dat_w     <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
    end else begin
      if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_BUS;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_adr   <= w_head_adr;
            r_dat_w <= w_head_dat;
            r_we    <= w_head_we;
            r_sel   <= w_head_sel;
          end
        end
        S_BUS: begin
          // ERR beats ACK, and either beats a timeout on the same edge.
          if (m.err || m.ack || (r_cnt == CNT_LAST)) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= m.err;
            r_rsp_tmo   <= !m.err && !m.ack;
            r_rsp_dat   <= (m.ack && !m.err && !r_we) ? m.dat_r : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m.adr   = r_adr;
  assign m.dat_w = r_dat_w;
  assign m.we    = r_we;
  assign m.sel   = r_sel;
  assign m.cyc   = r_cyc;
  assign m.stb   = r_cyc;

  assign cmd_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign rsp_tmo   = r_rsp_tmo;
  assign busy      = !w_empty || (r_state != S_IDLE) || r_rsp_valid;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed table, hand-written corner sequences and
// a randomized run scored against an in-order response queue.
module tb_wb_cmd_master;
  localparam logic [31:0] K = 32'hDEADBEFF;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_cmd_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo), .busy(busy),
    .m(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: 0 = ack one cycle after STB, 1 = never answers, 2 = ACK+ERR, 3 = ERR
  int slave_mode = 0;
  assign bus.dat_r = bus.adr ^ K;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
      if (bus.cyc && bus.stb && !bus.ack && !bus.err) begin
        case (slave_mode)
          0: bus.ack <= 1'b1;
          2: begin bus.ack <= 1'b1; bus.err <= 1'b1; end
          3: bus.err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Bus monitor and response scoreboard, sampled on the falling edge.
  bit          sb_en = 0;
  logic [31:0] exp_q[$];
  int          n_rise = 0, cur_len = 0, last_len = 0, cur_acks = 0, last_acks = 0;
  int          stab_err = 0, rsp_hi = 0, sb_cmds = 0, sb_rsps = 0;
  logic        prev_cyc = 1'b0;
  logic [68:0] prev_bus = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_cyc = 1'b0;
    end else begin
      if (bus.cyc !== bus.stb) stab_err++;
      if (bus.cyc && prev_cyc && ({bus.adr, bus.dat_w, bus.we, bus.sel} !== prev_bus)) stab_err++;
      if (bus.cyc && !prev_cyc) begin n_rise++; cur_len = 0; cur_acks = 0; end
      if (bus.cyc) begin cur_len++; if (bus.ack) cur_acks++; end
      if (!bus.cyc && prev_cyc) begin last_len = cur_len; last_acks = cur_acks; end
      prev_cyc = bus.cyc;
      prev_bus = {bus.adr, bus.dat_w, bus.we, bus.sel};
      if (rsp_valid) rsp_hi++;
      if (sb_en) begin
        if (cmd_valid && cmd_ready) begin
          exp_q.push_back(cmd_we ? 32'h0 : (cmd_adr ^ K));
          sb_cmds++;
        end
        if (rsp_valid && rsp_ready) begin
          sb_rsps++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_rsp", 1, 0);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check($sformatf("sb_dat%0d", sb_rsps), rsp_dat, e);
            check($sformatf("sb_flags%0d", sb_rsps), {rsp_err, rsp_tmo}, 2'b00);
          end
        end
      end
    end
  end

  // Offers one command; returns one cycle after the accepting edge (+#1).
  task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    bit ok;
    ok = 0;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
    end
    check("push_accept", ok, 1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          mode;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_len;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit drv_done;
    int r0, h0;
    vecs[0] = '{1'b0, 32'h10,       32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h20,       32'h12345678, 4'h3, 0, 32'h0,        1'b0, 1'b0, 2};
    vecs[2] = '{1'b1, 32'h30,       32'hCAFEF00D, 4'hF, 2, 32'h0,        1'b1, 1'b0, 2};
    vecs[3] = '{1'b0, 32'h40,       32'h0,        4'hF, 3, 32'h0,        1'b1, 1'b0, 2};
    vecs[4] = '{1'b0, 32'h50,       32'h0,        4'hF, 1, 32'h0,        1'b0, 1'b1, 16};
    vecs[5] = '{1'b0, 32'h1234,     32'h0,        4'h1, 0, 32'hDEADACCB, 1'b0, 1'b0, 2};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h0,        4'hF, 2, 32'h0,        1'b1, 1'b0, 2};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_tmo, busy}, 4'b0000);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_bus_ctl", {bus.cyc, bus.stb, bus.we}, 3'b000);
    check("rst_bus_dat", {bus.adr, bus.dat_w, bus.sel}, 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Latency: accept at E, CYC after E+1, rsp_valid after E+3, single ACK.
    slave_mode = 0;
    cmd_we = 1'b0; cmd_adr = 32'h10; cmd_dat = '0; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("lat_cyc_E", bus.cyc, 0);
    @(posedge clk); #1;
    check("lat_cyc_E1", {bus.cyc, bus.stb}, 2'b11);
    check("lat_rsp_E1", rsp_valid, 0);
    @(posedge clk); #1;
    check("lat_rsp_E2", rsp_valid, 0);
    @(posedge clk); #1;
    check("lat_rsp_E3", rsp_valid, 1);
    check("lat_dat", rsp_dat, 32'hDEADBEEF);
    check("lat_flags", {rsp_err, rsp_tmo}, 2'b00);
    @(posedge clk); #1;
    check("lat_acks", last_acks, 1);
    check("lat_hold", {rsp_valid, rsp_dat}, {1'b1, 32'hDEADBEEF});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("lat_consumed", {rsp_valid, busy}, 2'b00);

    // Directed table: termination kinds and their response fields.
    foreach (vecs[i]) begin
      slave_mode = vecs[i].mode;
      push_cmd(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
      cmd_valid = 1'b0;
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        got = rsp_valid;
      end
      check($sformatf("vec%0d_rsp_seen", i), got, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_dat", i), rsp_dat, vecs[i].exp_dat);
      check($sformatf("vec%0d_err", i), rsp_err, vecs[i].exp_err);
      check($sformatf("vec%0d_tmo", i), rsp_tmo, vecs[i].exp_tmo);
      check($sformatf("vec%0d_cyc_len", i), last_len, vecs[i].exp_len);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check($sformatf("vec%0d_consumed", i), rsp_valid, 0);
    end

    // Five back-to-back commands with the response slot blocked.
    slave_mode = 0; sb_en = 1; r0 = n_rise;
    for (int i = 0; i < 5; i++) push_cmd(1'(i & 1), 32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 4'hF);
    cmd_valid = 1'b0;
    check("b2b_full", cmd_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_still_full", cmd_ready, 0);
    check("b2b_one_cycle", n_rise - r0, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || busy); c++) begin
      @(posedge clk); #1;
    end
    check("b2b_drained", {exp_q.size() == 0, busy}, 2'b10);
    check("b2b_cycles", n_rise - r0, 5);
    rsp_ready = 1'b0;
    sb_en = 0;

    // Reset in the middle of a bus cycle with two commands queued.
    slave_mode = 1;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 32'h200 + 32'(i), 32'h0, 4'hF);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_in_bus", bus.cyc, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_cyc_stb", {bus.cyc, bus.stb}, 2'b00);
    check("mid_rst_state", {rsp_valid, cmd_ready, busy}, 3'b010);
    @(negedge clk); rstn = 1'b1;
    slave_mode = 0; rsp_ready = 1'b1;
    r0 = n_rise; h0 = rsp_hi;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_no_cycle", n_rise - r0, 0);
    check("post_rst_no_rsp", rsp_hi - h0, 0);
    rsp_ready = 1'b0;

    // Random commands and random rsp_ready against the acking slave.
    sb_en = 1; slave_mode = 0; drv_done = 0;
    sb_cmds = 0; sb_rsps = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          cmd_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
        cmd_valid = 1'b0;
        drv_done = 1;
      end
      begin
        for (int c = 0; c < 5000 && !(drv_done && exp_q.size() == 0 && !busy); c++) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || busy); c++) begin
      @(posedge clk); #1;
    end
    check("rand_cmd_count", sb_cmds, 60);
    check("rand_rsp_count", sb_rsps, sb_cmds);
    check("rand_queue_empty", exp_q.size(), 0);
    check("bus_stability", stab_err, 0);
    sb_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
